// File: rtl/fir_decim_buf_pkg.sv
// Shared FIR sample types and constants for the decimating output buffer.
// Holds the FIR output tuple, the FIFO storage array and the DECIM/depth limits.
package FIR_types;

  localparam int DECIM_MIN  = 1;
  localparam int DECIM_MAX  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int LEVEL_W    = 3;

  // sel0: signed sample, sel1: valid bit
  typedef struct packed {
    logic signed [15:0] sel0;
    logic               sel1;
  } Tup2_3;

  typedef logic signed [15:0] array_of_4_signed_16 [0:FIFO_DEPTH-1];

  // Out-of-range factors are pulled into the legal window rather than mis-sizing the phase counter
  function automatic int clamp_decim(input int d);
    if (d < DECIM_MIN) return DECIM_MIN;
    if (d > DECIM_MAX) return DECIM_MAX;
    return d;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Four-entry sample FIFO; the head is always a register, so it never depends on this cycle's inputs.
// Pointers wrap modulo 4 and level alone tells full from empty.
module fir_sample_fifo
  import FIR_types::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic signed [15:0]  data,
  output logic signed [15:0]  head,
  output logic [LEVEL_W-1:0]  level
);

  array_of_4_signed_16  mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LEVEL_W-1:0]   level_next;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 3'd1;
      2'b01:   level_next = level - 3'd1;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      // Flush wins over any coincident push or pop
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fir_decim_buf.sv
// Decimates the FIR output stream by DECIM and buffers kept samples in a 4-deep FIFO.
// A kept sample arriving while the FIFO is full and not draining is dropped and latched in ovf.
module fir_decim_buf
  import FIR_types::*;
#(
  parameter int DECIM = 2
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  Tup2_3               in_sample,
  input  logic                flush,
  input  logic                clr_ovf,
  output logic signed [15:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          level,
  output logic                ovf
);

  localparam int         DECIM_EFF  = clamp_decim(DECIM);
  localparam logic [2:0] LAST_PHASE = 3'(DECIM_EFF - 1);

  logic [2:0] phase;
  logic       kept;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;

  assign out_valid = (level != 3'd0);
  assign full      = (level == 3'(FIFO_DEPTH));
  assign kept      = in_sample.sel1 && (phase == 3'd0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push      = kept && (!full || pop);
  assign drop      = kept && full && !pop && !flush;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      phase <= '0;
    end else if (flush) begin
      phase <= '0;
    end else if (in_sample.sel1) begin
      phase <= (phase == LAST_PHASE) ? 3'd0 : phase + 3'd1;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  fir_sample_fifo u_fifo (
    .clk   (system1000),
    .rst_n (system1000_rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .data  (in_sample.sel0),
    .head  (out_data),
    .level (level)
  );

endmodule

// File: tb/tb_fir_decim_buf.sv
// Directed bench for fir_decim_buf: three instances (DECIM=1,2,3) share one stimulus stream.
module tb_fir_decim_buf;
  import FIR_types::*;

  logic  clk = 1'b0;
  logic  rstn = 1'b0;
  Tup2_3 in_sample;
  logic  flush = 1'b0;
  logic  clr_ovf = 1'b0;
  logic  out_ready = 1'b0;

  logic signed [15:0] out_data1, out_data2, out_data3;
  logic               out_valid1, out_valid2, out_valid3;
  logic [2:0]         level1, level2, level3;
  logic               ovf1, ovf2, ovf3;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fir_decim_buf #(.DECIM(1)) u1 (
    .system1000(clk), .system1000_rstn(rstn), .in_sample(in_sample), .flush(flush),
    .clr_ovf(clr_ovf), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .level(level1), .ovf(ovf1));
  fir_decim_buf #(.DECIM(2)) u2 (
    .system1000(clk), .system1000_rstn(rstn), .in_sample(in_sample), .flush(flush),
    .clr_ovf(clr_ovf), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .level(level2), .ovf(ovf2));
  fir_decim_buf #(.DECIM(3)) u3 (
    .system1000(clk), .system1000_rstn(rstn), .in_sample(in_sample), .flush(flush),
    .clr_ovf(clr_ovf), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .level(level3), .ovf(ovf3));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [15:0] d, input logic v);
    in_sample.sel0 = d;
    in_sample.sel1 = v;
  endtask

  initial begin
    drive(16'sd0, 1'b0);

    // Reset state while the clock has not yet ticked
    #2;
    chk("rst_valid", out_valid2, 0);
    chk("rst_level", level2, 0);
    chk("rst_ovf", ovf2, 0);
    chk("rst_data", out_data2, 0);
    #6 rstn = 1'b1;

    // DECIM=2 pass-through: 10 and 30 kept, one cycle latency
    out_ready = 1'b1;
    drive(16'sd10, 1'b1); step();
    chk("d2_valid_a", out_valid2, 1);
    chk("d2_data_a", out_data2, 10);
    drive(16'sd20, 1'b1); step();
    chk("d2_valid_b", out_valid2, 0);
    drive(16'sd30, 1'b1); step();
    chk("d2_valid_c", out_valid2, 1);
    chk("d2_data_c", out_data2, 30);
    drive(16'sd40, 1'b1); step();
    chk("d2_valid_d", out_valid2, 0);
    chk("d2_ovf", ovf2, 0);
    drive(16'sd0, 1'b0); flush = 1'b1; step(); flush = 1'b0;

    // DECIM=1 overflow: fill with 1..4, drop 5
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(16'(i), 1'b1); step();
    end
    chk("ov_level4", level1, 4);
    chk("ov_ovf_pre", ovf1, 0);
    drive(16'sd5, 1'b1); step();
    chk("ov_level", level1, 4);
    chk("ov_ovf", ovf1, 1);
    chk("ov_head", out_data1, 1);
    drive(16'sd0, 1'b0); out_ready = 1'b1; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ov_clr", ovf1, 0);
    chk("drain_2", out_data1, 2);
    step(); chk("drain_3", out_data1, 3);
    step(); chk("drain_4", out_data1, 4);
    step(); chk("drain_empty", out_valid1, 0);
    chk("drain_level", level1, 0);

    // DECIM=1 full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      drive(16'(i), 1'b1); step();
    end
    drive(16'sd7, 1'b1); out_ready = 1'b1; step();
    chk("pp_level", level1, 4);
    chk("pp_head", out_data1, 12);
    chk("pp_ovf", ovf1, 0);
    drive(16'sd0, 1'b0);
    step(); chk("pp_13", out_data1, 13);
    step(); chk("pp_14", out_data1, 14);
    step(); chk("pp_7", out_data1, 7);
    step(); chk("pp_empty", level1, 0);

    // Stall holds the head stable
    out_ready = 1'b0;
    drive(16'sd33, 1'b1); step();
    drive(16'sd0, 1'b0); step(); step();
    chk("hold_data", out_data1, 33);
    chk("hold_valid", out_valid1, 1);

    // Flush with a coincident kept sample, ovf survives, then clr_ovf
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 21; i <= 25; i++) begin
      drive(16'(i), 1'b1); step();
    end
    drive(16'sd0, 1'b0); out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("fl_level3", level1, 3);
    chk("fl_ovf_pre", ovf1, 1);
    drive(16'sd99, 1'b1); flush = 1'b1; step();
    flush = 1'b0; drive(16'sd0, 1'b0);
    chk("fl_level", level1, 0);
    chk("fl_valid", out_valid1, 0);
    chk("fl_ovf_kept", ovf1, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("fl_clr", ovf1, 0);

    // DECIM=3 with sel1=0 gaps: only -5 and 8 come out
    out_ready = 1'b1;
    drive(-16'sd5, 1'b1); step();
    chk("d3_valid_a", out_valid3, 1);
    chk("d3_data_a", out_data3, -5);
    drive(16'sd1, 1'b0); step();
    chk("d3_gap_a", out_valid3, 0);
    drive(16'sd6, 1'b1); step();
    chk("d3_skip_6", out_valid3, 0);
    drive(16'sd2, 1'b0); step();
    drive(-16'sd7, 1'b1); step();
    chk("d3_skip_m7", out_valid3, 0);
    drive(16'sd99, 1'b0); step();
    chk("d3_gap_c", out_valid3, 0);
    drive(16'sd8, 1'b1); step();
    chk("d3_valid_b", out_valid3, 1);
    chk("d3_data_b", out_data3, 8);
    drive(16'sd0, 1'b0); step();
    chk("d3_end", out_valid3, 0);

    // Asynchronous reset mid-cycle with DECIM=2 holding two samples
    flush = 1'b1; step(); flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 50; i <= 53; i++) begin
      drive(16'(i), 1'b1); step();
    end
    drive(16'sd0, 1'b0);
    chk("ar_level2", level2, 2);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", out_valid2, 0);
    chk("ar_level", level2, 0);
    chk("ar_ovf", ovf2, 0);
    #1 rstn = 1'b1;
    drive(16'sd60, 1'b1); step();
    chk("ar_keep_v", out_valid2, 1);
    chk("ar_keep_d", out_data2, 60);
    drive(16'sd61, 1'b1); step();
    chk("ar_phase1", level2, 1);
    drive(16'sd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_decim_buf.md
FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

Interface
REQ-001 SHALL provide parameter DECIM, default 2, meaning decimation factor, legal range 1..8.
REQ-002 SHALL have a fixed FIFO depth of 4 entries; depth is not a parameter.
REQ-003 SHALL have port system1000, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port system1000_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_sample, input, Tup2_3 (17 bits): FIR output; sel0 is the signed 16-bit sample, sel1 is the valid bit.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of the phase counter and FIFO.
REQ-007 SHALL have port clr_ovf, input, 1 bit: synchronous clear of the overflow flag.
REQ-008 SHALL have port out_data, output, signed 16 bits: FIFO head sample.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 SHALL have port level, output, 3 bits: FIFO occupancy, 0..4.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when a kept sample is dropped.

Function
REQ-013 SHALL keep a phase counter 0..DECIM-1 that advances only on cycles where in_sample.sel1=1, and wraps from DECIM-1 to 0.
REQ-014 SHALL mark a valid input sample as kept when its phase is 0; all other valid samples are discarded.
REQ-015 SHALL ignore in_sample.sel0 when sel1=0; the phase does not change on those cycles.
REQ-016 SHALL push a kept sample when level<4, or when level=4 and a pop occurs in the same cycle.
REQ-017 SHALL drop a kept sample and set ovf on the next edge when level=4 and no pop occurs in that cycle; FIFO contents stay unchanged.
REQ-018 SHALL drive out_valid = (level!=0) and out_data = FIFO head; both come from registers, with no combinational path from in_sample or out_ready.
REQ-019 SHALL pop on cycles where out_valid=1 and out_ready=1 (handshake); a pop with level=0 is impossible by construction.
REQ-020 SHALL make a sample kept at cycle N with level=0 visible on out_data/out_valid at cycle N+1 (1-cycle latency).
REQ-021 SHALL on simultaneous push and pop keep level unchanged and preserve order (FIFO head advances, new sample appended).
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL wrap read/write pointers modulo 4; level alone distinguishes full from empty.
REQ-024 SHALL on flush=1 set level to 0, set both pointers and the phase to 0, and discard any coincident push or pop; ovf is unaffected.
REQ-025 SHALL on clr_ovf=1 clear ovf; if an overflow occurs in the same cycle, ovf remains 1 (set wins).
REQ-026 SHALL with DECIM=1 keep every valid sample.

Reset
REQ-027 SHALL on system1000_rstn=0 immediately force out_valid=0, level=0, ovf=0, out_data=0, phase=0, and pointers=0, regardless of clock.
REQ-028 SHALL when reset is asserted mid-operation discard all buffered samples; the first valid sample after release is phase 0 and is kept.

Structure
REQ-029 SHALL take Tup2_3 and array_of_4_signed_16 (FIFO storage) from the shared FIR_types package; no new sample typedefs are added.
REQ-030 SHALL place the DECIM range limits and the FIFO depth constant 4 in FIR_types.
REQ-031 SHALL implement the FIFO as one sub-module, fir_sample_fifo (push, pop, flush, data, level), instantiated once; decimation logic stays in fir_decim_buf.

Verification
REQ-032 SHALL cover this scenario: DECIM=2, out_ready=1, valid samples 10,20,30,40 on consecutive cycles -> out_data 10 then 30, each 1 cycle after input; ovf stays 0.
REQ-033 SHALL cover this scenario: DECIM=1, out_ready=0, valid samples 1..5 -> level reaches 4, sample 5 dropped, ovf=1, then draining yields 1,2,3,4 in order.
REQ-034 SHALL cover this scenario: DECIM=1, level=4, out_ready=1, valid sample 7 in the same cycle -> level stays 4, head advances, 7 becomes the last entry, ovf=0.
REQ-035 SHALL cover this scenario: DECIM=3, valid inputs interleaved with sel1=0 gaps, values -5,6,-7,8 -> outputs -5 and 8 only (phase not advanced during gaps).
REQ-036 SHALL cover this scenario: level=3 with ovf=1, flush and a kept sample in the same cycle -> level=0 and out_valid=0 next cycle, ovf still 1; clr_ovf -> ovf=0.
REQ-037 SHALL cover this scenario: system1000_rstn pulsed low between clock edges with level=2 -> out_valid, level and ovf go to 0 without a clock edge; next valid sample after release is kept.
